hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Parametrised successor to the pipeline hazard detector; sits beside the ID stage of the 5-stage MIPS core.
//  Detects load-use, ID-resolved branch/jump-register and multi-cycle mult/div hazards on the instruction in ID.
//  Freezes PC and IF/ID and injects a bubble into EXE while any hazard is active.
//  Tracks the mult/div busy window and counts stall cycles for performance monitoring.
// PARAMETERS
//  REG_AW       5       register address width
//  SRC_W        3       width of RF write-data source select
//  LOAD_SRC     3'b100  RF_WD_Src encoding meaning "data memory" (load)
//  BRANCH_IN_ID 1       1: beq/bne/jr/jalr compare in ID (check EXE write and MEM load); 0: treat them as ordinary R/I readers
//  MULDIV_LAT   4       cycles mult/div occupies HI/LO, counted from the issue cycle; legal range >= 1
//  PERF_W       16      stall-cycle counter width
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  instr_id      in   32      instruction currently in ID
//  rf_wa_exe     in   REG_AW  destination register of the EXE instruction
//  rf_wd_src_exe in   SRC_W   write-data source of the EXE instruction
//  we_reg_exe    in   1       EXE instruction writes RF
//  rf_wa_mem     in   REG_AW  destination register of the MEM instruction
//  rf_wd_src_mem in   SRC_W   write-data source of the MEM instruction
//  we_reg_mem    in   1       MEM instruction writes RF
//  muldiv_start  in   1       EXE is issuing mult/multu/div/divu this cycle
//  perf_clr      in   1       synchronous clear of stall_cycles
//  pc_enable     out  1       1 = PC and IF/ID advance; 0 = hold
//  ins_nop       out  1       1 = load a bubble into ID/EXE; always equals ~pc_enable
//  stall_reason  out  3       bit0 load-use, bit1 branch/jr, bit2 mult/div; several bits may be set together
//  muldiv_busy   out  1       HI/LO not yet valid
//  stall_cycles  out  PERF_W  saturating count of cycles with ins_nop=1
// BEHAVIOUR
//  - Register $0 never causes a hazard: any match where the source register is 0 is ignored.
//  - Sources: R-type reads rs and rt. Exceptions: mfhi/mflo (funct 010000/010010) read none; jr/jalr read rs only.
//  - Sources: opcodes 001xxx except lui (001111) read rs; lw (100011) reads rs; sw (101011) reads rs and rt.
//  - Sources: beq/bne (00010x) read rs and rt. J-type and everything else reads none.
//  - Load-use (bit0): a source matches rf_wa_exe, with we_reg_exe=1 and rf_wd_src_exe==LOAD_SRC.
//  - Branch (bit1): applies only when BRANCH_IN_ID=1 and ID holds beq/bne/jr/jalr. Condition A: a source matches rf_wa_exe with we_reg_exe=1, any write-data source.
//  - Branch (bit1), condition B: a source matches rf_wa_mem with we_reg_mem=1 and rf_wd_src_mem==LOAD_SRC. Either condition sets bit1.
//  - Mult/div (bit2): ID holds mfhi, mflo, or mult/multu/div/divu (funct 0110xx), and busy_now is 1.
//  - busy_now = muldiv_start | (mcnt != 0).
//  - mcnt is a $clog2(MULDIV_LAT+1)-bit down-counter. On muldiv_start it loads MULDIV_LAT-1; otherwise, when nonzero, it decrements.
//  - muldiv_busy = busy_now. A start in cycle T keeps the unit busy for cycles T..T+MULDIV_LAT-1.
//  - A muldiv_start while already busy reloads the counter (restart); no error is flagged.
//  - Stall: pc_enable = ~|stall_reason and ins_nop = |stall_reason. All hazard terms are combinational with zero latency.
//  - stall_cycles: when perf_clr=1 it goes to 0, and perf_clr has priority. Otherwise it increments when ins_nop=1 and holds at all-ones.
//  - Reset (rst_n=0, asynchronous): mcnt=0 and stall_cycles=0.
//  - While rst_n=0, outputs are forced to pc_enable=1, ins_nop=0, stall_reason=0 and muldiv_busy=0, regardless of inputs.
//  - Reset mid-busy abandons the window; after release no mult/div stall remains.
// TESTING
//  1. EXE: lw to $8 (wa=8, src=100, we=1); ID: add $9,$8,$10 -> pc_enable=0, ins_nop=1, stall_reason=001. Next cycle EXE bubble -> no stall.
//  2. BRANCH_IN_ID=1; ID: beq $8,$9; EXE writes $9, src=000 -> stall_reason=010. Same with wa=0 -> no stall.
//  3. MULDIV_LAT=4: muldiv_start at T; ID: mflo from T -> stall at T..T+3, pc_enable=1 at T+4. muldiv_busy mirrors the same window.
//  4. rst_n low at T+1 of scenario 3, released at T+2 -> muldiv_busy=0 and no stall from T+2 onward; stall_cycles=0.
//  5. PERF_W=4: hold load-use for 20 cycles -> stall_cycles saturates at 15. perf_clr together with a stall -> 0.
//  6. BRANCH_IN_ID=0: beq $8 with an EXE ALU write to $8 -> no stall. With an EXE load to $8 -> stall_reason=001.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage load-use, branch and mult/div hazard detection with PC/IF-ID freeze and stall counting
module hazard_stall_ctrl #(
    parameter int               REG_AW       = 5,
    parameter int               SRC_W        = 3,
    parameter logic [SRC_W-1:0] LOAD_SRC     = SRC_W'(3'b100),
    parameter bit               BRANCH_IN_ID = 1'b1,
    parameter int               MULDIV_LAT   = 4,
    parameter int               PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_id,
    input  logic [REG_AW-1:0] rf_wa_exe,
    input  logic [SRC_W-1:0]  rf_wd_src_exe,
    input  logic              we_reg_exe,
    input  logic [REG_AW-1:0] rf_wa_mem,
    input  logic [SRC_W-1:0]  rf_wd_src_mem,
    input  logic              we_reg_mem,
    input  logic              muldiv_start,
    input  logic              perf_clr,
    output logic              pc_enable,
    output logic              ins_nop,
    output logic [2:0]        stall_reason,
    output logic              muldiv_busy,
    output logic [PERF_W-1:0] stall_cycles
);
    localparam int MCW = $clog2(MULDIV_LAT + 1);
    logic [5:0]        op, funct;
    logic [REG_AW-1:0] rs, rt;
    logic              is_r, is_hilo, is_jr, is_md, is_br, rd_rs, rd_rt;
    logic              hit_exe, hit_mem, busy_now;
    logic [2:0]        reason;
    logic [MCW-1:0]    mcnt;
    logic              unused_ok;

    assign op        = instr_id[31:26];
    assign funct     = instr_id[5:0];
    assign rs        = REG_AW'(instr_id[25:21]);
    assign rt        = REG_AW'(instr_id[20:16]);
    assign unused_ok = ^instr_id[15:6];

    assign is_r    = op == 6'd0;
    assign is_hilo = is_r && (funct == 6'b010000 || funct == 6'b010010);
    assign is_jr   = is_r && funct[5:1] == 5'b00100;
    assign is_md   = is_r && funct[5:2] == 4'b0110;
    assign is_br   = BRANCH_IN_ID && (is_jr || op[5:1] == 5'b00010);
    assign rd_rs   = (is_r && !is_hilo) || (op[5:3] == 3'b001 && op != 6'b001111)
                   || op == 6'b100011 || op == 6'b101011 || op[5:1] == 5'b00010;
    assign rd_rt   = (is_r && !is_hilo && !is_jr) || op == 6'b101011 || op[5:1] == 5'b00010;

    // $0 reads are filtered here so no hazard term can ever fire on them
    assign hit_exe = (rd_rs && rs != '0 && rs == rf_wa_exe) || (rd_rt && rt != '0 && rt == rf_wa_exe);
    assign hit_mem = (rd_rs && rs != '0 && rs == rf_wa_mem) || (rd_rt && rt != '0 && rt == rf_wa_mem);
    assign busy_now = muldiv_start || mcnt != '0;

    assign reason[0] = hit_exe && we_reg_exe && rf_wd_src_exe == LOAD_SRC;
    assign reason[1] = is_br && ((hit_exe && we_reg_exe) || (hit_mem && we_reg_mem && rf_wd_src_mem == LOAD_SRC));
    assign reason[2] = (is_hilo || is_md) && busy_now;

    // outputs present a clean, non-stalling view while reset is asserted
    always_comb begin
        stall_reason = rst_n ? reason : 3'b000;
        pc_enable    = ~|stall_reason;
        ins_nop      = |stall_reason;
        muldiv_busy  = rst_n && busy_now;
    end

    // HI/LO busy window: a start (or restart) covers its own cycle plus MULDIV_LAT-1 more
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mcnt <= '0;
        else if (muldiv_start)
            mcnt <= MCW'(MULDIV_LAT - 1);
        else if (mcnt != '0)
            mcnt <= mcnt - 1'b1;
    end

    // saturating stall-cycle counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (perf_clr)
            stall_cycles <= '0;
        else if (ins_nop && !(&stall_cycles))
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scenarios plus random traffic against a rule-level reference model
module tb_hazard_stall_ctrl;
    localparam int LAT = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic [4:0]  wa_e = '0, wa_m = '0;
    logic [2:0]  src_e = '0, src_m = '0;
    logic        we_e = 1'b0, we_m = 1'b0, ms = 1'b0, pclr = 1'b0;
    logic        pe1, nop1, mb1, pe0, nop0, mb0;
    logic [2:0]  sr1, sr0;
    logic [3:0]  sc1;
    logic [15:0] sc0;
    int          n_chk = 0, n_err = 0, cyc = 0, last_start = -1000, cnt1 = 0, cnt0 = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.BRANCH_IN_ID(1'b1), .MULDIV_LAT(LAT), .PERF_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_id(instr), .rf_wa_exe(wa_e), .rf_wd_src_exe(src_e),
        .we_reg_exe(we_e), .rf_wa_mem(wa_m), .rf_wd_src_mem(src_m), .we_reg_mem(we_m),
        .muldiv_start(ms), .perf_clr(pclr), .pc_enable(pe1), .ins_nop(nop1),
        .stall_reason(sr1), .muldiv_busy(mb1), .stall_cycles(sc1));

    hazard_stall_ctrl #(.BRANCH_IN_ID(1'b0), .MULDIV_LAT(LAT), .PERF_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .instr_id(instr), .rf_wa_exe(wa_e), .rf_wd_src_exe(src_e),
        .we_reg_exe(we_e), .rf_wa_mem(wa_m), .rf_wd_src_mem(src_m), .we_reg_mem(we_m),
        .muldiv_start(ms), .perf_clr(pclr), .pc_enable(pe0), .ins_nop(nop0),
        .stall_reason(sr0), .muldiv_busy(mb0), .stall_cycles(sc0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [5:0] f);
        return {6'd0, s, t, 5'($urandom), 5'($urandom), f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t);
        return {o, s, t, 16'($urandom)};
    endfunction

    // registers read by an instruction; an unused slot is reported as $0, which never hazards anyway
    function automatic void sources(input logic [31:0] i, output int a, output int b);
        int o, f;
        o = int'(i[31:26]);
        f = int'(i[5:0]);
        a = 0;
        b = 0;
        if (o == 0) begin
            if (f == 8 || f == 9) a = int'(i[25:21]);
            else if (f != 16 && f != 18) begin a = int'(i[25:21]); b = int'(i[20:16]); end
        end else if ((o >= 8 && o <= 14) || o == 35) a = int'(i[25:21]);
        else if (o == 43 || o == 4 || o == 5) begin a = int'(i[25:21]); b = int'(i[20:16]); end
    endfunction

    function automatic bit model_busy();
        return ms || (cyc - last_start >= 1 && cyc - last_start <= LAT - 1);
    endfunction

    function automatic logic [2:0] model_reason(input bit bid);
        int a, b, o, f, we, wm;
        bit lu, br, md;
        if (!rst_n) return 3'b000;
        sources(instr, a, b);
        o = int'(instr[31:26]);
        f = int'(instr[5:0]);
        we = int'(wa_e);
        wm = int'(wa_m);
        lu = we_e && src_e == 3'b100 && we != 0 && (we == a || we == b);
        br = bid && (o == 4 || o == 5 || (o == 0 && (f == 8 || f == 9)))
             && ((we_e && we != 0 && (we == a || we == b))
                 || (we_m && src_m == 3'b100 && wm != 0 && (wm == a || wm == b)));
        md = o == 0 && (f == 16 || f == 18 || (f >= 24 && f <= 27)) && model_busy();
        return {md, br, lu};
    endfunction

    task automatic run_cycle();
        logic [2:0] r1, r0;
        #1;
        if (!rst_n) begin last_start = -1000; cnt1 = 0; cnt0 = 0; end
        r1 = model_reason(1'b1);
        r0 = model_reason(1'b0);
        check("sr1", sr1, r1);
        check("pe1", pe1, r1 == 0);
        check("nop1", nop1, r1 != 0);
        check("mb1", mb1, rst_n && model_busy());
        check("sc1", sc1, cnt1);
        check("sr0", sr0, r0);
        check("pe0", pe0, r0 == 0);
        check("mb0", mb0, rst_n && model_busy());
        check("sc0", sc0, cnt0);
        @(posedge clk);
        if (!rst_n) begin
            last_start = -1000; cnt1 = 0; cnt0 = 0;
        end else begin
            if (ms) last_start = cyc;
            cnt1 = pclr ? 0 : (r1 != 0 && cnt1 < 15) ? cnt1 + 1 : cnt1;
            cnt0 = pclr ? 0 : (r0 != 0 && cnt0 < 65535) ? cnt0 + 1 : cnt0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_exe(input logic [4:0] wa, input logic [2:0] src, input logic we);
        wa_e = wa; src_e = src; we_e = we;
    endtask

    task automatic set_mem(input logic [4:0] wa, input logic [2:0] src, input logic we);
        wa_m = wa; src_m = src; we_m = we;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] regs [5];
        regs = '{5'd0, 5'd8, 5'd9, 5'd10, 5'd31};
        return regs[$urandom_range(0, 4)];
    endfunction

    initial begin
        @(negedge clk);
        instr = rtype(5'd8, 5'd10, 6'd32);
        set_exe(5'd8, 3'b100, 1'b1);
        ms = 1'b1;
        #1 check("rst_forced_pe", pe1, 1'b1);
        check("rst_forced_mb", mb1, 1'b0);
        check("rst_sc", sc1, 4'd0);
        run_cycle();
        ms = 1'b0;
        rst_n = 1'b1;
        // load-use then bubble
        #1 check("s1_reason", sr1, 3'b001);
        check("s1_pc", pe1, 1'b0);
        check("s1_nop", nop1, 1'b1);
        run_cycle();
        set_exe(5'd0, 3'b000, 1'b0);
        #1 check("s1_bubble", nop1, 1'b0);
        run_cycle();
        // branch in ID vs EXE ALU write, $0 write, MEM load
        instr = itype(6'd4, 5'd8, 5'd9);
        set_exe(5'd9, 3'b000, 1'b1);
        #1 check("s2_reason", sr1, 3'b010);
        check("s6_alu_noid", sr0, 3'b000);
        run_cycle();
        set_exe(5'd0, 3'b000, 1'b1);
        #1 check("s2_wa0", sr1, 3'b000);
        run_cycle();
        set_exe(5'd0, 3'b000, 1'b0);
        set_mem(5'd8, 3'b100, 1'b1);
        #1 check("s2_memload", sr1, 3'b010);
        run_cycle();
        set_mem(5'd8, 3'b000, 1'b1);
        #1 check("s2_memalu", sr1, 3'b000);
        run_cycle();
        set_mem(5'd0, 3'b000, 1'b0);
        // mult/div busy window
        instr = rtype(5'd0, 5'd0, 6'd18);
        ms = 1'b1;
        #1 check("s3_T", sr1, 3'b100);
        check("s3_busyT", mb1, 1'b1);
        run_cycle();
        ms = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            #1 check("s3_win", sr1, 3'b100);
            check("s3_busy", mb1, 1'b1);
            run_cycle();
        end
        #1 check("s3_end_pc", pe1, 1'b1);
        check("s3_end_busy", mb1, 1'b0);
        run_cycle();
        // reset mid-busy
        ms = 1'b1;
        run_cycle();
        ms = 1'b0;
        rst_n = 1'b0;
        #1 check("s4_rst_busy", mb1, 1'b0);
        check("s4_rst_sc", sc1, 4'd0);
        run_cycle();
        rst_n = 1'b1;
        #1 check("s4_after_busy", mb1, 1'b0);
        check("s4_after_pc", pe1, 1'b1);
        run_cycle();
        run_cycle();
        // saturation and clear priority
        instr = rtype(5'd8, 5'd10, 6'd32);
        set_exe(5'd8, 3'b100, 1'b1);
        repeat (20) run_cycle();
        #1 check("s5_sat", sc1, 4'd15);
        pclr = 1'b1;
        run_cycle();
        pclr = 1'b0;
        #1 check("s5_clr", sc1, 4'd0);
        run_cycle();
        // no branch resolution in ID: only load-use applies
        instr = itype(6'd4, 5'd8, 5'd0);
        set_exe(5'd8, 3'b000, 1'b1);
        #1 check("s6_alu", sr0, 3'b000);
        run_cycle();
        set_exe(5'd8, 3'b100, 1'b1);
        #1 check("s6_load", sr0, 3'b001);
        check("s6_load_id", sr1, 3'b011);
        run_cycle();
        // random traffic
        repeat (3000) begin
            case ($urandom_range(0, 13))
                0:  instr = rtype(pick_reg(), pick_reg(), 6'd32);
                1:  instr = rtype(pick_reg(), pick_reg(), 6'd16);
                2:  instr = rtype(pick_reg(), pick_reg(), 6'd18);
                3:  instr = rtype(pick_reg(), pick_reg(), 6'd8);
                4:  instr = rtype(pick_reg(), pick_reg(), 6'd9);
                5:  instr = rtype(pick_reg(), pick_reg(), 6'(24 + $urandom_range(0, 3)));
                6:  instr = itype(6'(8 + $urandom_range(0, 6)), pick_reg(), pick_reg());
                7:  instr = itype(6'd15, pick_reg(), pick_reg());
                8:  instr = itype(6'd35, pick_reg(), pick_reg());
                9:  instr = itype(6'd43, pick_reg(), pick_reg());
                10: instr = itype(6'd4, pick_reg(), pick_reg());
                11: instr = itype(6'd5, pick_reg(), pick_reg());
                12: instr = itype(6'd2, pick_reg(), pick_reg());
                default: instr = $urandom;
            endcase
            set_exe(pick_reg(), ($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom), 1'($urandom));
            set_mem(pick_reg(), ($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom), 1'($urandom));
            ms    = $urandom_range(0, 7) == 0;
            pclr  = $urandom_range(0, 29) == 0;
            rst_n = $urandom_range(0, 49) != 0;
            run_cycle();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
